// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   tx_state_t      : transmitter FSM state
//   ST_*            : bit positions inside the status word
//   *_ADDR_DEF      : default register addresses on the core data port
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

  localparam logic [31:0] TX_ADDR_DEF     = 32'h0000_8000;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_8004;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   push/wdata : write request; ignored when full unless a pop happens on the same edge
//   pop        : read request; rdata always shows the head entry
//   full/empty/count : occupancy (count is AW+1 bits)
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A pop on the same edge frees the slot being written, so a full FIFO still accepts.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data port.
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   MemWrite, DataAdr,
//   WriteData           : core store strobe, address and data (bits [7:0] used)
//   io_sel              : DataAdr hits TX_ADDR or STATUS_ADDR (used to gate RAM writes)
//   IoReadData          : status word when DataAdr==STATUS_ADDR, else 0
//   uart_tx             : registered serial line, idle high
//   tx_busy             : registered, transmitter not idle
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = uart_pkg::TX_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR  = uart_pkg::STATUS_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        io_sel,
  output logic [31:0] IoReadData,
  output logic        uart_tx,
  output logic        tx_busy
);

  import uart_pkg::*;

  localparam int unsigned    AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned    BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          txd;
  logic          busy;
  logic          overflow;

  logic          hit_tx;
  logic          hit_st;
  logic          bit_end;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [AW:0]   fifo_count;
  logic          ovf_set;
  logic          ovf_clr;
  logic [31:0]   status;
  logic          unused_wdata;

  assign hit_tx    = (DataAdr == TX_ADDR);
  assign hit_st    = (DataAdr == STATUS_ADDR);
  assign io_sel    = hit_tx || hit_st;
  assign fifo_push = MemWrite && hit_tx;
  assign bit_end   = (baud == BAUD_LAST);
  // Pop from IDLE, or on the last STOP cycle so frames run back to back.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;
  assign ovf_clr   = MemWrite && hit_st && WriteData[ST_OVF];
  assign unused_wdata = ^WriteData[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (WriteData[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_comb begin
    status                           = '0;
    status[ST_FULL]                  = fifo_full;
    status[ST_EMPTY]                 = fifo_empty;
    status[ST_BUSY]                  = busy;
    status[ST_OVF]                   = overflow;
    status[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(fifo_count);
    IoReadData                       = hit_st ? status : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      baud   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      txd    <= 1'b1;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shreg <= fifo_rdata;
            baud  <= '0;
            txd   <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud   <= '0;
            bitcnt <= '0;
            txd    <= shreg[0];
            shreg  <= {1'b0, shreg[7:1]};
            state  <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bitcnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              txd    <= shreg[0];
              shreg  <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (fifo_pop) begin
              shreg <= fifo_rdata;
              txd   <= 1'b0;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx = txd;
  assign tx_busy = busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] TXA   = 32'h0000_8000;
  localparam logic [31:0] STA   = 32'h0000_8004;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        io_sel;
  logic [31:0] IoReadData;
  logic        uart_tx;
  logic        tx_busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TX_ADDR      (TXA),
    .STATUS_ADDR  (STA)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .io_sel     (io_sel),
    .IoReadData (IoReadData),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  int unsigned e1          = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: bytes expected on the line, in order, and frame start times.
  logic [7:0]  exp_q [$];
  int unsigned starts [$];

  bit          mon_active = 1'b0;
  bit          mon_kill   = 1'b0;
  int          mon_cnt    = 0;
  logic [7:0]  mon_byte;
  int          frames     = 0;

  always @(posedge clk) if (reset === 1'b0) mon_kill = 1'b1;

  // Frame decoder, sampling mid-bit on falling edges.
  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_kill) begin
      mon_active = 1'b0;
      mon_kill   = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        vectors++;
        if (uart_tx !== 1'b0) begin
          miscompares++;
          $display("FAIL start_bit: uart_tx=%b expected 0", uart_tx);
        end
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0) begin
        mon_byte[(mon_cnt - 6) / 4] = uart_tx;
      end else if (mon_cnt == 38) begin
        vectors++;
        if (uart_tx !== 1'b1) begin
          miscompares++;
          $display("FAIL stop_bit: uart_tx=%b expected 1", uart_tx);
        end
        frames++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_unexpected: got byte %h, expected no frame", mon_byte);
        end else begin
          e = exp_q.pop_front();
          if (mon_byte !== e) begin
            miscompares++;
            $display("FAIL frame_byte: got %h expected %h", mon_byte, e);
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  function automatic logic [31:0] mk_status(input int cnt, input bit ovf, input bit busy);
    logic [31:0] r;
    r    = '0;
    r[0] = (cnt == DEPTH);
    r[1] = (cnt == 0);
    r[2] = busy;
    r[3] = ovf;
    r[7:4] = 4'(cnt);
    return r;
  endfunction

  task automatic wait_drain(input int budget, output bit ok);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (n < budget);
  endtask

  task automatic test_reset;
    reset = 1'b0; MemWrite = 1'b0; DataAdr = STA; WriteData = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx: %b expected 1", uart_tx); end
    vectors++;
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: %b expected 0", tx_busy); end
    vectors++;
    if (IoReadData !== 32'h2) begin miscompares++; $display("FAIL reset_status: %h expected %h", IoReadData, 32'h2); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode;
    int lows;
    DataAdr = STA; MemWrite = 1'b0; #1;
    vectors++;
    if (io_sel !== 1'b1 || IoReadData !== 32'h2) begin miscompares++; $display("FAIL dec_status: io_sel=%b rd=%h expected 1/%h", io_sel, IoReadData, 32'h2); end
    DataAdr = TXA; #1;
    vectors++;
    if (io_sel !== 1'b1 || IoReadData !== 32'h0) begin miscompares++; $display("FAIL dec_tx: io_sel=%b rd=%h expected 1/0", io_sel, IoReadData); end
    DataAdr = 32'h0000_0010; #1;
    vectors++;
    if (io_sel !== 1'b0 || IoReadData !== 32'h0) begin miscompares++; $display("FAIL dec_ram: io_sel=%b rd=%h expected 0/0", io_sel, IoReadData); end
    DataAdr = 32'h0000_8008; #1;
    vectors++;
    if (io_sel !== 1'b0) begin miscompares++; $display("FAIL dec_8008: io_sel=%b expected 0", io_sel); end
    // A store to RAM must not reach the FIFO.
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = 32'h0000_0010; WriteData = 32'h77;
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = STA; #1;
    vectors++;
    if (IoReadData !== 32'h2) begin miscompares++; $display("FAIL ram_store_status: %h expected %h", IoReadData, 32'h2); end
    lows = 0;
    repeat (20) begin @(negedge clk); if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++; end
    vectors++;
    if (lows != 0) begin miscompares++; $display("FAIL ram_store_line: %0d active cycles expected 0", lows); end
  endtask

  task automatic test_single_frame;
    logic [7:0] b;
    logic       exp_bit;
    int         s;
    bit         ok;
    b = 8'h55;
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = TXA; WriteData = {24'hFFFFFF, b};
    exp_q.push_back(b);
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = STA; #1;
    vectors++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || IoReadData !== mk_status(1, 0, 0)) begin
      miscompares++;
      $display("FAIL latency: tx=%b busy=%b st=%h expected 1/0/%h", uart_tx, tx_busy, IoReadData, mk_status(1, 0, 0));
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      s = k / 4;
      if (s == 0) exp_bit = 1'b0;
      else if (s == 9) exp_bit = 1'b1;
      else exp_bit = b[s-1];
      vectors++;
      if (uart_tx !== exp_bit || tx_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL wave[%0d]: tx=%b busy=%b expected %b/1", k, uart_tx, tx_busy, exp_bit);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || IoReadData !== 32'h2) begin
      miscompares++;
      $display("FAIL after_frame: tx=%b busy=%b st=%h expected 1/0/%h", uart_tx, tx_busy, IoReadData, 32'h2);
    end
    wait_drain(20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL drain_single: queue=%0d busy=%b expected 0/0", exp_q.size(), tx_busy); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) e1 = cyc + 1;
      MemWrite = 1'b1; DataAdr = TXA; WriteData = 32'(i);
      // Byte 0 leaves for the shifter one edge after it lands, so 0..8 fit and 9 is dropped.
      if (i <= 8) exp_q.push_back(8'(i));
    end
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = STA; #1;
    vectors++;
    if (IoReadData !== mk_status(8, 1, 1)) begin
      miscompares++;
      $display("FAIL overflow_status: %h expected %h", IoReadData, mk_status(8, 1, 1));
    end
  endtask

  task automatic test_overflow_clear;
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = STA; WriteData = 32'hF7;
    @(negedge clk);
    MemWrite = 1'b0; #1;
    vectors++;
    if (IoReadData !== mk_status(8, 1, 1)) begin
      miscompares++;
      $display("FAIL status_write_ignored: %h expected %h", IoReadData, mk_status(8, 1, 1));
    end
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = STA; WriteData = 32'h08;
    @(negedge clk);
    MemWrite = 1'b0; #1;
    vectors++;
    if (IoReadData !== mk_status(8, 0, 1)) begin
      miscompares++;
      $display("FAIL overflow_clear: %h expected %h", IoReadData, mk_status(8, 0, 1));
    end
  endtask

  task automatic test_full_push_pop;
    int unsigned b0;
    bit          ok;
    b0 = starts.size() - 1;
    // The first burst frame started at edge e1+1; its last STOP cycle ends at e1+41.
    while (cyc + 1 < e1 + 41) @(negedge clk);
    DataAdr = STA; #1;
    vectors++;
    if (IoReadData !== mk_status(8, 0, 1)) begin
      miscompares++;
      $display("FAIL pre_pop_status: %h expected %h", IoReadData, mk_status(8, 0, 1));
    end
    MemWrite = 1'b1; DataAdr = TXA; WriteData = 32'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = STA; #1;
    vectors++;
    if (IoReadData !== mk_status(8, 0, 1)) begin
      miscompares++;
      $display("FAIL push_pop_full: %h expected %h", IoReadData, mk_status(8, 0, 1));
    end
    wait_drain(600, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL drain_burst: queue=%0d busy=%b expected 0/0", exp_q.size(), tx_busy); end
    vectors++;
    if (starts.size() - b0 != 10) begin
      miscompares++;
      $display("FAIL burst_frames: %0d frames expected 10", starts.size() - b0);
    end else begin
      for (int k = 0; k < 9; k++) begin
        vectors++;
        if (starts[b0+k+1] - starts[b0+k] != 40) begin
          miscompares++;
          $display("FAIL b2b_gap[%0d]: %0d cycles expected 40", k, starts[b0+k+1] - starts[b0+k]);
        end
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (IoReadData !== 32'h2) begin miscompares++; $display("FAIL burst_end_status: %h expected %h", IoReadData, 32'h2); end
  endtask

  task automatic test_reset_midframe;
    int lows;
    int f0;
    @(negedge clk);
    MemWrite = 1'b1; DataAdr = TXA; WriteData = 32'h3C;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    MemWrite = 1'b0; DataAdr = STA;
    // 18 more falling edges land in the second cycle of data bit 3.
    repeat (18) @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL midframe_busy: %b expected 1", tx_busy); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    void'(exp_q.pop_front());
    f0 = frames;
    #1;
    vectors++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || IoReadData !== 32'h2) begin
      miscompares++;
      $display("FAIL midframe_reset: tx=%b busy=%b st=%h expected 1/0/%h", uart_tx, tx_busy, IoReadData, 32'h2);
    end
    lows = 0;
    repeat (60) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    vectors++;
    if (lows != 0 || frames != f0) begin
      miscompares++;
      $display("FAIL post_reset_idle: low=%0d frames=%0d expected 0/%0d", lows, frames, f0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    bit ok;
    test_reset();
    test_decode();
    test_single_frame();
    test_overflow();
    test_overflow_clear();
    test_full_push_pop();
    test_reset_midframe();
    wait_drain(100, ok);
    vectors++;
    if (!ok || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d bytes left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
